// File: rtl/cpu_pkg.sv
// Shared types for the multi-cycle CPU: opcodes, FSM states, instruction layout
// and decode helpers.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_MOV   = 4'h0,
        OP_ADD   = 4'h1,
        OP_SUB   = 4'h2,
        OP_CMP   = 4'h3,
        OP_MOVI  = 4'h4,
        OP_ADDI  = 4'h5,
        OP_SUBI  = 4'h6,
        OP_CMPI  = 4'h7,
        OP_PUSH  = 4'h8,
        OP_POP   = 4'h9,
        OP_ILL_A = 4'hA,
        OP_ILL_B = 4'hB,
        OP_JMP   = 4'hC,
        OP_JZ    = 4'hD,
        OP_JNZ   = 4'hE,
        OP_HLT   = 4'hF
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        IMM,
        EXEC,
        HALT,
        FAULT
    } state_e;

    typedef enum logic [1:0] {
        ALU_PASS,
        ALU_ADD,
        ALU_SUB
    } alu_op_e;

    typedef logic [1:0] reg_idx_t;

    typedef struct packed {
        op_e      op;
        reg_idx_t rd;
        reg_idx_t rs;
    } instr_t;

    // Immediate-form ALU ops and jumps carry a trailing immediate word.
    function automatic logic needs_imm(op_e op);
        return op[2] && (op != OP_HLT);
    endfunction

    function automatic logic is_illegal(op_e op);
        return (op == OP_ILL_A) || (op == OP_ILL_B);
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational datapath ALU: pass-through, add or subtract with zero detect.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_e           op,
    output logic [DATA_W-1:0] result_c,
    output logic              zero_c
);

    always_comb begin
        result_c = b;
        unique case (op)
            ALU_ADD: result_c = a + b;
            ALU_SUB: result_c = a - b;
            default: result_c = b;
        endcase
        zero_c = (result_c == '0);
    end

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle fetch/immediate/execute CPU with run-time loadable program memory,
// a full-descending stack and halt/fault status.
module multicycle_cpu
    import cpu_pkg::*;
#(
    parameter  int unsigned DATA_W    = 8,
    parameter  int unsigned MEM_DEPTH = 64,
    localparam int unsigned ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic              start,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] OUT,
    output logic              halted,
    output logic              fault,
    output logic              busy
);

    localparam int unsigned SUM_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] regs_q [4];
    logic [DATA_W-1:0] regs_d [4];
    logic [ADDR_W-1:0] ip_q, ip_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic              zf_q, zf_d;
    instr_t            ir_q, ir_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic              halted_q, halted_d;
    logic              fault_q, fault_d;
    logic              busy_q, busy_d;

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];
    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_waddr_c;
    logic [DATA_W-1:0] mem_wdata_c;

    alu_op_e           alu_op_c;
    logic [DATA_W-1:0] alu_b_c;
    logic [DATA_W-1:0] alu_result_c;
    logic              alu_zero_c;
    logic [ADDR_W-1:0] sp_dec_c;
    logic [ADDR_W-1:0] jmp_tgt_c;

    // Immediate forms take the operand from imm; op[1:0] selects mov/add/sub/cmp.
    always_comb begin
        alu_op_c = ALU_PASS;
        if (ir_q.op[1:0] == 2'b01) begin
            alu_op_c = ALU_ADD;
        end else if (ir_q.op[1]) begin
            alu_op_c = ALU_SUB;
        end
        alu_b_c   = ir_q.op[2] ? imm_q : regs_q[ir_q.rs];
        sp_dec_c  = sp_q - ADDR_W'(1);
        // Sign-extended offset from the post-immediate ip, wrapping modulo MEM_DEPTH.
        jmp_tgt_c = ADDR_W'(SUM_W'(ip_q) + SUM_W'($signed(imm_q)));
    end

    cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a        (regs_q[ir_q.rd]),
        .b        (alu_b_c),
        .op       (alu_op_c),
        .result_c (alu_result_c),
        .zero_c   (alu_zero_c)
    );

    always_comb begin
        state_d     = state_q;
        regs_d      = regs_q;
        ip_d        = ip_q;
        sp_d        = sp_q;
        zf_d        = zf_q;
        ir_d        = ir_q;
        imm_d       = imm_q;
        mem_we_c    = 1'b0;
        mem_waddr_c = load_addr;
        mem_wdata_c = load_data;

        unique case (state_q)
            IDLE, HALT, FAULT: begin
                if (load_we) begin
                    mem_we_c = 1'b1;
                end
                if (start) begin
                    ip_d    = '0;
                    sp_d    = '0;
                    zf_d    = 1'b0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                ir_d = instr_t'(mem_q[ip_q][7:0]);
                ip_d = ip_q + ADDR_W'(1);
                if (is_illegal(ir_d.op)) begin
                    state_d = FAULT;
                end else if (needs_imm(ir_d.op)) begin
                    state_d = IMM;
                end else begin
                    state_d = EXEC;
                end
            end
            IMM: begin
                imm_d   = mem_q[ip_q];
                ip_d    = ip_q + ADDR_W'(1);
                state_d = EXEC;
            end
            EXEC: begin
                state_d = FETCH;
                unique case (ir_q.op)
                    OP_MOV, OP_ADD, OP_SUB, OP_CMP,
                    OP_MOVI, OP_ADDI, OP_SUBI, OP_CMPI: begin
                        if (ir_q.op[1:0] != 2'b11) begin
                            regs_d[ir_q.rd] = alu_result_c;
                        end
                        if (ir_q.op[1:0] != 2'b00) begin
                            zf_d = alu_zero_c;
                        end
                    end
                    OP_PUSH: begin
                        sp_d        = sp_dec_c;
                        mem_we_c    = 1'b1;
                        mem_waddr_c = sp_dec_c;
                        mem_wdata_c = regs_q[ir_q.rs];
                    end
                    OP_POP: begin
                        regs_d[ir_q.rd] = mem_q[sp_q];
                        sp_d            = sp_q + ADDR_W'(1);
                    end
                    OP_JMP: ip_d = jmp_tgt_c;
                    OP_JZ: begin
                        if (zf_q) begin
                            ip_d = jmp_tgt_c;
                        end
                    end
                    OP_JNZ: begin
                        if (!zf_q) begin
                            ip_d = jmp_tgt_c;
                        end
                    end
                    OP_HLT:  state_d = HALT;
                    default: state_d = FAULT;
                endcase
            end
            default: state_d = IDLE;
        endcase

        halted_d = (state_d == HALT);
        fault_d  = (state_d == FAULT);
        busy_d   = (state_d == FETCH) || (state_d == IMM) || (state_d == EXEC);
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
            ip_q     <= '0;
            sp_q     <= '0;
            zf_q     <= 1'b0;
            ir_q     <= '0;
            imm_q    <= '0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            regs_q   <= regs_d;
            ip_q     <= ip_d;
            sp_q     <= sp_d;
            zf_q     <= zf_d;
            ir_q     <= ir_d;
            imm_q    <= imm_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
            busy_q   <= busy_d;
        end
    end

    // Program/stack memory keeps its contents across reset.
    always_ff @(posedge CLOCK) begin
        if (mem_we_c) begin
            mem_q[mem_waddr_c] <= mem_wdata_c;
        end
    end

    assign OUT    = regs_q[0];
    assign halted = halted_q;
    assign fault  = fault_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_multicycle_cpu.sv
// Scoreboard bench for multicycle_cpu: an 8-bit/64-word core and a 16-bit/256-word core.
module tb_multicycle_cpu;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;

    logic        start8 = 1'b0, we8 = 1'b0;
    logic [5:0]  addr8  = '0;
    logic [7:0]  data8  = '0;
    logic [7:0]  out8;
    logic        halted8, fault8, busy8;

    logic        start16 = 1'b0, we16 = 1'b0;
    logic [7:0]  addr16  = '0;
    logic [15:0] data16  = '0;
    logic [15:0] out16;
    logic        halted16, fault16, busy16;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    int          bcnt;

    always #5 clk = ~clk;

    multicycle_cpu #(.DATA_W(8), .MEM_DEPTH(64)) u_dut8 (
        .CLOCK(clk), .RESET_N(rst_n), .start(start8), .load_we(we8),
        .load_addr(addr8), .load_data(data8), .OUT(out8),
        .halted(halted8), .fault(fault8), .busy(busy8)
    );

    multicycle_cpu #(.DATA_W(16), .MEM_DEPTH(256)) u_dut16 (
        .CLOCK(clk), .RESET_N(rst_n), .start(start16), .load_we(we16),
        .load_addr(addr16), .load_data(data16), .OUT(out16),
        .halted(halted16), .fault(fault16), .busy(busy16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_val(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic score(input string tag, input logic [31:0] got);
        logic [31:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check(tag, got, e);
    endtask

    task automatic load(input bit sel, input int addr, input logic [15:0] data);
        @(negedge clk);
        if (sel) begin
            we16 = 1'b1; addr16 = 8'(addr); data16 = data;
        end else begin
            we8 = 1'b1; addr8 = 6'(addr); data8 = data[7:0];
        end
        @(negedge clk);
        we8  = 1'b0;
        we16 = 1'b0;
    endtask

    task automatic load_prog(input bit sel, input logic [15:0] prog[$]);
        foreach (prog[i]) load(sel, i, prog[i]);
    endtask

    // Pulse start, count busy cycles until halt/fault; optionally write memory with
    // start (with_load) or at busy cycle inj_cyc.
    task automatic run(input bit sel, input int inj_cyc, input bit with_load,
                       input int ld_addr, input logic [15:0] ld_data, output int busy_cnt);
        bit done;
        done     = 1'b0;
        busy_cnt = 0;
        @(negedge clk);
        if (sel) start16 = 1'b1; else start8 = 1'b1;
        if (with_load) begin
            if (sel) begin we16 = 1'b1; addr16 = 8'(ld_addr); data16 = ld_data; end
            else begin we8 = 1'b1; addr8 = 6'(ld_addr); data8 = ld_data[7:0]; end
        end
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            start8 = 1'b0; start16 = 1'b0; we8 = 1'b0; we16 = 1'b0;
            if (sel ? busy16 : busy8) busy_cnt++;
            if (sel ? (halted16 | fault16) : (halted8 | fault8)) begin
                done = 1'b1;
            end else if (i == inj_cyc) begin
                we8 = 1'b1; addr8 = 6'(ld_addr); data8 = ld_data[7:0];
            end
        end
        we8 = 1'b0;
        check("run_done", 32'(done), 32'd1);
    endtask

    initial begin
        logic [15:0] fib[$];
        logic [15:0] stk[$];
        logic [15:0] p16[$];
        fib = '{16'h40, 16'h01, 16'h44, 16'h01, 16'h48, 16'h00, 16'h4C, 16'h01, 16'h09,
                16'h04, 16'h12, 16'h5C, 16'h01, 16'h7C, 16'h09, 16'hE0, 16'hF7, 16'hF0};
        stk = '{16'h40, 16'h5A, 16'h80, 16'h40, 16'h00, 16'h94, 16'hF0};
        p16 = '{16'h0040, 16'hFFFF, 16'h0050, 16'h0001, 16'h00F0};

        #1 rst_n = 1'b0;
        #1;
        check("rst_out8", 32'(out8), 32'd0);
        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_halted8", 32'(halted8), 32'd0);
        check("rst_fault8", 32'(fault8), 32'd0);
        check("rst_out16", 32'(out16), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        load_prog(1'b0, fib);

        // Abort mid-run with an asynchronous reset between clock edges.
        @(negedge clk); start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        repeat (20) @(negedge clk);
        check("midrun_busy", 32'(busy8), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out", 32'(out8), 32'd0);
        check("midrst_busy", 32'(busy8), 32'd0);
        check("midrst_halted", 32'(halted8), 32'd0);
        check("midrst_fault", 32'(fault8), 32'd0);
        check("midrst_d", 32'(u_dut8.regs_q[3]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        expect_val(134); expect_val(32'h37); expect_val(9); expect_val(1); expect_val(0);
        run(1'b0, -1, 1'b0, 0, 16'h0, bcnt);
        score("fib_cycles", 32'(bcnt));
        score("fib_out", 32'(out8));
        score("fib_d", 32'(u_dut8.regs_q[3]));
        score("fib_halted", 32'(halted8));
        score("fib_fault", 32'(fault8));

        // Attempt to overwrite the hlt at address 17 with an illegal opcode while busy.
        expect_val(134); expect_val(32'h37); expect_val(1); expect_val(32'hF0);
        run(1'b0, 5, 1'b0, 17, 16'h00A0, bcnt);
        score("blk_cycles", 32'(bcnt));
        score("blk_out", 32'(out8));
        score("blk_halted", 32'(halted8));
        score("blk_mem17", 32'(u_dut8.mem_q[17]));

        load_prog(1'b0, stk);
        expect_val(12); expect_val(32'h5A); expect_val(32'h5A); expect_val(0);
        expect_val(1); expect_val(0);
        run(1'b0, -1, 1'b0, 0, 16'h0, bcnt);
        score("stk_cycles", 32'(bcnt));
        score("stk_mem63", 32'(u_dut8.mem_q[63]));
        score("stk_b", 32'(u_dut8.regs_q[1]));
        score("stk_sp", 32'(u_dut8.sp_q));
        score("stk_halted", 32'(halted8));
        score("stk_out", 32'(out8));

        load(1'b0, 0, 16'h00A0);
        expect_val(1); expect_val(1); expect_val(0);
        run(1'b0, -1, 1'b0, 0, 16'h0, bcnt);
        score("ill_cycles", 32'(bcnt));
        score("ill_fault", 32'(fault8));
        score("ill_halted", 32'(halted8));

        load(1'b0, 40, 16'h005A);
        expect_val(32'h5A); expect_val(1);
        score("ill_load_mem40", 32'(u_dut8.mem_q[40]));
        score("ill_fault_sticky", 32'(fault8));

        // start together with a write to address 0: the first fetch sees the new hlt.
        expect_val(2); expect_val(0); expect_val(1);
        run(1'b0, -1, 1'b1, 0, 16'h00F0, bcnt);
        score("restart_cycles", 32'(bcnt));
        score("restart_fault", 32'(fault8));
        score("restart_halted", 32'(halted8));

        load_prog(1'b1, p16);
        expect_val(8); expect_val(0); expect_val(1); expect_val(1);
        run(1'b1, -1, 1'b0, 0, 16'h0, bcnt);
        score("w16_cycles", 32'(bcnt));
        score("w16_out", 32'(out16));
        score("w16_zf", 32'(u_dut16.zf_q));
        score("w16_halted", 32'(halted16));

        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
